pw_vault: RTL and testbench
===========================

// Module: pw_vault
// PURPOSE
//  Password store and checker for the door-lock datapath; the consumer end of the lock FSM's password bus.
//  Takes the 17-bit password bus {change_flag, 4 BCD digits} and the 2-bit FSM state.
//  Returns pw_valid to the FSM.
//  Also: commits a new password when change mode ends, counts failed unlock attempts, enforces a timed lockout.
// PARAMETERS
//  DEFAULT_PW   16'h1234      reset value of stored password (4 BCD digits, MSD in [15:12])
//  MAX_FAIL     3             consecutive failed attempts that trigger lockout (1..15)
//  LOCK_CYCLES  50_000_000    lockout duration in clk cycles (>=2)
//  LOCK_W       26            width of lockout timer; 2**LOCK_W > LOCK_CYCLES
//  MASTER_PW    16'h9999      master password (used only with PW_MASTER_KEY_EN)
// PORTS
//  clk             in   1   system clock, all logic on posedge
//  reset_n         in   1   asynchronous reset, active low
//  pws_in          in   17  [16]=change mode flag, [15:0]=entered digits, BCD
//  state_in        in   2   FSM state: 00 lock, 01 waiting, 10 open, 11 change
//  pw_valid_out    out  1   registered match flag to FSM
//  lockout_out     out  1   high while lockout timer runs
//  fail_cnt_out    out  4   consecutive failed attempts
//  commit_ok_out   out  1   1-cycle pulse: new password stored
//  commit_err_out  out  1   1-cycle pulse: new password rejected
// BEHAVIOUR
//  Reset (async, all regs):
//   - pw_q=DEFAULT_PW, shadow=0, chg_d=0, state_d=00, fail_cnt=0, lock timer=0.
//   - All outputs 0.
//   - Reset mid-change discards the shadow; pw_q returns to DEFAULT_PW.
//  Match, 1-cycle latency:
//   - pw_valid_out <= (pws_in[15:0]==pw_q) && !lockout, sampled every cycle.
//   - Digits are stable >=1 cycle before the confirm key edge, so the FSM sees a settled value.
//  Change capture:
//   - chg_d <= pws_in[16].
//   - While pws_in[16]==1: shadow <= pws_in[15:0] each cycle.
//   - Falling edge (chg_d==1 && pws_in[16]==0): shadow holds the last digits before the bus clears to 0.
//     - All 4 nibbles <=9: pw_q <= shadow; commit_ok_out=1 next cycle.
//     - Any nibble >9: pw_q unchanged; commit_err_out=1 next cycle.
//   - Rising edge of pws_in[16] has no effect other than starting capture.
//  Attempt tracking:
//   - state_d <= state_in.
//   - Attempt end = state_d==01 and state_in!=01.
//   - Success (state_in==10): fail_cnt <= 0.
//   - Failure (state_in==00): fail_cnt <= fail_cnt+1.
//     - If the new value == MAX_FAIL: lockout=1, timer <= LOCK_CYCLES-1, fail_cnt holds MAX_FAIL.
//   - fail_cnt saturates at MAX_FAIL, never wraps.
//  Lockout:
//   - Timer decrements each cycle. Lockout deasserts the cycle after the timer reads 0; fail_cnt <= 0 then.
//   - During lockout, failures are not counted and do not restart the timer.
//   - pw_valid_out is held 0 during lockout.
//   - Password change is not blocked (open/change are unreachable without valid).
//  Simultaneous events:
//   - Expiry and attempt end in the same cycle: expiry first, then the attempt is counted on the cleared count.
//   - Commit and attempt end cannot coincide (exclusive FSM states). If forced, both take effect independently.
//   - Illegal state_in values are impossible; 2-bit states are all decoded.
// CONFIGURATION
//  PW_MASTER_KEY_EN defined:
//   - pw_valid_out also 1 when pws_in[15:0]==MASTER_PW, even during lockout.
//   - A success attempt end with lockout active clears lockout, timer and fail_cnt in the same cycle.
//   - Master is never writable.
//  PW_MASTER_KEY_EN undefined:
//   - MASTER_PW ignored; only pw_q matches; lockout cannot be bypassed.
// TESTING
//  (bench: LOCK_CYCLES=16, LOCK_W=5, MAX_FAIL=3)
//  1. Reset, pws_in=0_1234 -> pw_valid_out=1 one cycle later; pws_in=0_1235 -> pw_valid_out=0 next cycle.
//  2. state 01->00 three times -> fail_cnt_out 1,2,3; lockout_out=1 for 16 cycles; pws_in=0_1234 gives valid=0 throughout.
//     After expiry: fail_cnt_out=0, valid=1.
//  3. Two fails then 01->10 -> fail_cnt_out=0.
//     Fourth failure during lockout -> fail_cnt_out stays 3, timer not restarted.
//  4. pws_in=1_5678 for 4 cycles, then 0_0000 -> commit_ok_out pulse.
//     pws_in=0_5678 -> valid=1; 0_1234 -> valid=0.
//  5. pws_in=1_56A8 then 0_0000 -> commit_err_out pulse; password still 1234.
//     Assert reset_n=0 mid-change (1_4321) -> after release, 1234 valid and 4321 not.
//  6. PW_MASTER_KEY_EN defined: during lockout pws_in=0_9999 -> valid=1.
//     01->10 -> lockout_out=0, fail_cnt_out=0 same cycle.
//     Undefined: 0_9999 -> valid=0.

Source files
------------

// File: rtl/pw_vault.sv
// Password store/checker for the door-lock datapath: match flag, password commit, failure count and timed lockout.
// Optional master key enabled by defining PW_MASTER_KEY_EN.
module pw_vault #(
   parameter logic [15:0] DEFAULT_PW  = 16'h1234,
   parameter int unsigned MAX_FAIL    = 3,
   parameter int unsigned LOCK_CYCLES = 50_000_000,
   parameter int unsigned LOCK_W      = 26,
   parameter logic [15:0] MASTER_PW   = 16'h9999
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [16:0] pws_in,
   input  logic [1:0]  state_in,
   output logic        pw_valid_out,
   output logic        lockout_out,
   output logic [3:0]  fail_cnt_out,
   output logic        commit_ok_out,
   output logic        commit_err_out
);

`ifdef PW_MASTER_KEY_EN
   localparam bit MASTER_EN = 1'b1;
`else
   localparam bit MASTER_EN = 1'b0;
`endif

   localparam logic [1:0] ST_LOCK = 2'b00;
   localparam logic [1:0] ST_WAIT = 2'b01;
   localparam logic [1:0] ST_OPEN = 2'b10;

   logic [15:0]       pw_q;
   logic [15:0]       shadow;
   logic              chg_d;
   logic [1:0]        state_d;
   logic [3:0]        fail_cnt;
   logic              lockout;
   logic [LOCK_W-1:0] timer;

   logic [15:0]       digits_c;
   logic              chg_c;
   logic              commit_c;
   logic              bcd_ok_c;
   logic              attempt_end_c;
   logic              success_c;
   logic              failure_c;
   logic              master_hit_c;
   logic              valid_c;
   logic [3:0]        fail_n_c;
   logic              lock_n_c;
   logic [LOCK_W-1:0] timer_n_c;

   // Decode bus, attempt boundaries and change-mode falling edge
   always_comb begin
      digits_c      = pws_in[15:0];
      chg_c         = pws_in[16];
      commit_c      = chg_d && !chg_c;
      bcd_ok_c      = (shadow[15:12] <= 4'd9) && (shadow[11:8] <= 4'd9) &&
                      (shadow[7:4]   <= 4'd9) && (shadow[3:0]  <= 4'd9);
      attempt_end_c = (state_d == ST_WAIT) && (state_in != ST_WAIT);
      success_c     = attempt_end_c && (state_in == ST_OPEN);
      failure_c     = attempt_end_c && (state_in == ST_LOCK);
      master_hit_c  = MASTER_EN && (digits_c == MASTER_PW);
      valid_c       = ((digits_c == pw_q) && !lockout) || master_hit_c;
   end

   // Lockout timer and failure counter; expiry is applied before the attempt is counted
   always_comb begin
      fail_n_c  = fail_cnt;
      lock_n_c  = lockout;
      timer_n_c = timer;
      if (lockout) begin
         if (timer == '0) begin
            lock_n_c = 1'b0;
            fail_n_c = 4'd0;
         end else begin
            timer_n_c = timer - LOCK_W'(1);
         end
      end
      if (success_c) begin
         fail_n_c = 4'd0;
         if (MASTER_EN && lockout) begin
            lock_n_c  = 1'b0;
            timer_n_c = '0;
         end
      end else if (failure_c && !lock_n_c) begin
         if (fail_n_c >= 4'(MAX_FAIL - 1)) begin
            fail_n_c  = 4'(MAX_FAIL);
            lock_n_c  = 1'b1;
            timer_n_c = LOCK_W'(LOCK_CYCLES - 1);
         end else begin
            fail_n_c = fail_n_c + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pw_q           <= DEFAULT_PW;
         shadow         <= 16'h0000;
         chg_d          <= 1'b0;
         state_d        <= ST_LOCK;
         fail_cnt       <= 4'd0;
         lockout        <= 1'b0;
         timer          <= '0;
         pw_valid_out   <= 1'b0;
         commit_ok_out  <= 1'b0;
         commit_err_out <= 1'b0;
      end else begin
         chg_d          <= chg_c;
         state_d        <= state_in;
         fail_cnt       <= fail_n_c;
         lockout        <= lock_n_c;
         timer          <= timer_n_c;
         pw_valid_out   <= valid_c;
         commit_ok_out  <= commit_c && bcd_ok_c;
         commit_err_out <= commit_c && !bcd_ok_c;
         if (chg_c) begin
            shadow <= digits_c;
         end
         if (commit_c && bcd_ok_c) begin
            pw_q <= shadow;
         end
      end
   end

   assign lockout_out  = lockout;
   assign fail_cnt_out = fail_cnt;

endmodule

// File: tb/tb_pw_vault.sv
// Directed bench for pw_vault with a short lockout (16 cycles, 3 failures).
// Define PW_MASTER_KEY_EN for both bench and RTL to cover the master-key build.
module tb_pw_vault;

   logic        clk;
   logic        reset_n;
   logic [16:0] pws_in;
   logic [1:0]  state_in;
   logic        pw_valid_out;
   logic        lockout_out;
   logic [3:0]  fail_cnt_out;
   logic        commit_ok_out;
   logic        commit_err_out;

   int checks = 0;
   int errors = 0;

   pw_vault #(
      .DEFAULT_PW  (16'h1234),
      .MAX_FAIL    (3),
      .LOCK_CYCLES (16),
      .LOCK_W      (5),
      .MASTER_PW   (16'h9999)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .pws_in         (pws_in),
      .state_in       (state_in),
      .pw_valid_out   (pw_valid_out),
      .lockout_out    (lockout_out),
      .fail_cnt_out   (fail_cnt_out),
      .commit_ok_out  (commit_ok_out),
      .commit_err_out (commit_err_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fail_attempt();
      state_in = 2'b01;
      tick();
      state_in = 2'b00;
      tick();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valid"},  32'(pw_valid_out),   32'd0);
      check({tag, "_lock"},   32'(lockout_out),    32'd0);
      check({tag, "_fail"},   32'(fail_cnt_out),   32'd0);
      check({tag, "_ok"},     32'(commit_ok_out),  32'd0);
      check({tag, "_err"},    32'(commit_err_out), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n  = 1'b0;
      pws_in   = 17'h0_0000;
      state_in = 2'b00;
      tick();
      tick();
      check_idle_outputs("rst");
      reset_n = 1'b1;

      // 1. basic match with one-cycle latency
      pws_in = 17'h0_1234;
      tick();
      check("t1_match", 32'(pw_valid_out), 32'd1);
      pws_in = 17'h0_1235;
      tick();
      check("t1_nomatch", 32'(pw_valid_out), 32'd0);

      // 2. three failures trigger a 16-cycle lockout
      fail_attempt();
      check("t2_fail1", 32'(fail_cnt_out), 32'd1);
      fail_attempt();
      check("t2_fail2", 32'(fail_cnt_out), 32'd2);
      pws_in = 17'h0_1234;
      fail_attempt();
      check("t2_fail3", 32'(fail_cnt_out), 32'd3);
      check("t2_lock_on", 32'(lockout_out), 32'd1);
      for (int i = 1; i <= 15; i++) begin
         tick();
         check("t2_lock_hold", 32'(lockout_out), 32'd1);
         check("t2_valid_blk", 32'(pw_valid_out), 32'd0);
      end
      tick();
      check("t2_lock_off", 32'(lockout_out), 32'd0);
      check("t2_fail_clr", 32'(fail_cnt_out), 32'd0);
      tick();
      check("t2_valid_back", 32'(pw_valid_out), 32'd1);

      // 3. success clears count; failure during lockout is ignored
      fail_attempt();
      fail_attempt();
      check("t3_fail2", 32'(fail_cnt_out), 32'd2);
      state_in = 2'b01;
      tick();
      state_in = 2'b10;
      tick();
      check("t3_success", 32'(fail_cnt_out), 32'd0);
      state_in = 2'b00;
      tick();
      fail_attempt();
      fail_attempt();
      fail_attempt();
      check("t3_lock_on", 32'(lockout_out), 32'd1);
      fail_attempt();
      check("t3_fail_sat", 32'(fail_cnt_out), 32'd3);
      check("t3_lock_still", 32'(lockout_out), 32'd1);
      for (int i = 3; i <= 15; i++) begin
         tick();
         check("t3_lock_hold", 32'(lockout_out), 32'd1);
      end
      tick();
      check("t3_no_restart", 32'(lockout_out), 32'd0);
      check("t3_fail_clr", 32'(fail_cnt_out), 32'd0);

      // 4. change password to 5678
      pws_in = 17'h1_5678;
      repeat (4) tick();
      check("t4_no_early_ok", 32'(commit_ok_out), 32'd0);
      pws_in = 17'h0_0000;
      tick();
      check("t4_commit_ok", 32'(commit_ok_out), 32'd1);
      check("t4_no_err", 32'(commit_err_out), 32'd0);
      pws_in = 17'h0_5678;
      tick();
      check("t4_ok_pulse", 32'(commit_ok_out), 32'd0);
      check("t4_new_valid", 32'(pw_valid_out), 32'd1);
      pws_in = 17'h0_1234;
      tick();
      check("t4_old_invalid", 32'(pw_valid_out), 32'd0);

      // 5. reject non-BCD password; reset mid-change restores the default
      reset_n = 1'b0;
      pws_in  = 17'h0_0000;
      #2;
      check_idle_outputs("t5_rst");
      reset_n = 1'b1;
      pws_in  = 17'h1_56A8;
      tick();
      pws_in = 17'h0_0000;
      tick();
      check("t5_commit_err", 32'(commit_err_out), 32'd1);
      check("t5_no_ok", 32'(commit_ok_out), 32'd0);
      pws_in = 17'h0_1234;
      tick();
      check("t5_err_pulse", 32'(commit_err_out), 32'd0);
      check("t5_pw_kept", 32'(pw_valid_out), 32'd1);
      pws_in = 17'h1_4321;
      tick();
      tick();
      reset_n = 1'b0;
      pws_in  = 17'h0_0000;
      #2;
      check("t5_rst_valid", 32'(pw_valid_out), 32'd0);
      reset_n = 1'b1;
      pws_in  = 17'h0_1234;
      tick();
      check("t5_default_ok", 32'(pw_valid_out), 32'd1);
      check("t5_no_commit", 32'(commit_ok_out), 32'd0);
      pws_in = 17'h0_4321;
      tick();
      check("t5_discarded", 32'(pw_valid_out), 32'd0);

      // 6. master key during lockout
      pws_in = 17'h0_1234;
      fail_attempt();
      fail_attempt();
      fail_attempt();
      check("t6_lock_on", 32'(lockout_out), 32'd1);
      pws_in = 17'h0_9999;
      tick();
`ifdef PW_MASTER_KEY_EN
      check("t6_master_valid", 32'(pw_valid_out), 32'd1);
`else
      check("t6_master_valid", 32'(pw_valid_out), 32'd0);
`endif
      state_in = 2'b01;
      tick();
      state_in = 2'b10;
      tick();
`ifdef PW_MASTER_KEY_EN
      check("t6_lock_clr", 32'(lockout_out), 32'd0);
      check("t6_fail_clr", 32'(fail_cnt_out), 32'd0);
`else
      check("t6_lock_kept", 32'(lockout_out), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
